mem_s: RTL

MEM_S -- requirements
Module: mem_s

---
 rtl/mem_s_pkg.sv | 39 +++
 rtl/mem_ld_align.sv | 27 ++
 rtl/mem_s.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_s_pkg.sv
// Shared CPU package for the memory stage: funct3 width codes, the
// memory-stage FSM state type and the active-low byte write-enable constants.
package mem_s_pkg;

  localparam logic [2:0] DT_LB  = 3'd0;
  localparam logic [2:0] DT_LH  = 3'd1;
  localparam logic [2:0] DT_LW  = 3'd2;
  localparam logic [2:0] DT_LBU = 3'd4;
  localparam logic [2:0] DT_LHU = 3'd5;
  localparam logic [2:0] DT_SB  = 3'd0;
  localparam logic [2:0] DT_SH  = 3'd1;
  localparam logic [2:0] DT_SW  = 3'd2;

  localparam logic [3:0] WEB_NONE    = 4'b1111;
  localparam logic [3:0] WEB_WORD    = 4'b0000;
  localparam logic [3:0] WEB_HALF_LO = 4'b1100;
  localparam logic [3:0] WEB_HALF_HI = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  function automatic logic dt_valid(input logic [2:0] dt, input logic is_store);
    if (is_store) return dt inside {DT_SB, DT_SH, DT_SW};
    return dt inside {DT_LB, DT_LH, DT_LW, DT_LBU, DT_LHU};
  endfunction

  function automatic logic [3:0] store_web(input logic [2:0] dt, input logic [1:0] a);
    case (dt)
      DT_SB:   return ~(4'b0001 << a);
      DT_SH:   return a[1] ? WEB_HALF_HI : WEB_HALF_LO;
      DT_SW:   return WEB_WORD;
      default: return WEB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_ld_align.sv
// Load data alignment: selects the byte/half/word addressed by addr[1:0]
// from the read word and sign- or zero-extends it to 32 bits.
module mem_ld_align
  import mem_s_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  datatype,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[{addr, 3'b000} +: 8];
    ld_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (datatype)
      DT_LB:   result = {{24{ld_byte[7]}}, ld_byte};
      DT_LBU:  result = {24'h0, ld_byte};
      DT_LH:   result = {{16{ld_half[15]}}, ld_half};
      DT_LHU:  result = {16'h0, ld_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_s.sv
// Pipeline MEM stage: data-memory handshake FSM, store lane steering, load
// alignment and the MEM/WB register. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_s
  import mem_s_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  datatype_i,
  input  logic [31:0] aluout_i,
  input  logic [31:0] dm_data_i,
  input  logic [31:0] pc2reg_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wr_i,
  input  logic        rd_src_i,
  input  logic        dm2reg_i,
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  output logic        dm_req_o,
  output logic [3:0]  dm_web_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic [31:0] dm_rdata_i,
  input  logic        dm_ack_i,
  output logic        mem_stall_o,
  output logic [31:0] mem_rd_data_o,
  output logic [4:0]  mem_rd_addr_o,
  output logic [31:0] wb_rd_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_wr_o,
  output logic        misalign_o
);

  mem_state_t  state_q, state_d;
  logic        mem_op, dt_ok, mis, acc_valid, wb_we;
  logic [31:0] fwd, ld_word, ld_res, hold_q;

  assign mem_op    = dm_rd_i | dm_wr_i;
  assign dt_ok     = dt_valid(datatype_i, dm_wr_i);
  assign acc_valid = mem_op & dt_ok & ~mis;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = mem_op & dt_ok &
               (((datatype_i[1:0] == 2'b01) & aluout_i[0]) |
                ((datatype_i[1:0] == 2'b10) & (aluout_i[1:0] != 2'b00)));

  always_ff @(posedge clk) begin
    if (!rst) misalign_o <= 1'b0;
    else      misalign_o <= mis;
  end
`else
  assign mis        = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign fwd           = rd_src_i ? pc2reg_i : aluout_i;
  assign mem_rd_data_o = fwd;
  assign mem_rd_addr_o = rd_addr_i;
  assign dm_addr_o     = {aluout_i[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (acc_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (dm_ack_i)  state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A held reset also blocks a fresh request from the still-presented instruction.
  always_comb begin
    dm_req_o    = 1'b0;
    mem_stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dm_req_o    = acc_valid & rst;
        mem_stall_o = acc_valid & rst;
      end
      ST_ACCESS: begin
        dm_req_o    = 1'b1;
        mem_stall_o = ~dm_ack_i;
      end
      default: ;
    endcase
  end

  assign dm_web_o = (dm_req_o & dm_wr_i) ? store_web(datatype_i, aluout_i[1:0]) : WEB_NONE;

  always_comb begin
    case (datatype_i[1:0])
      2'b00:   dm_wdata_o = {4{dm_data_i[7:0]}};
      2'b01:   dm_wdata_o = {2{dm_data_i[15:0]}};
      default: dm_wdata_o = dm_data_i;
    endcase
  end

  mem_ld_align u_ld_align (
    .addr     (aluout_i[1:0]),
    .datatype (datatype_i),
    .rdata    (dm_rdata_i),
    .result   (ld_word)
  );

  // Live aligned data on the ack cycle, otherwise the captured load result.
  assign ld_res = (state_q == ST_ACCESS) ? ld_word : hold_q;
  assign wb_we  = reg_wr_i & (rd_addr_i != 5'd0) & ~(mem_op & ~dt_ok) & ~mis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_rd_data_o <= '0;
      wb_rd_addr_o <= '0;
      wb_reg_wr_o  <= 1'b0;
      hold_q       <= '0;
    end else begin
      if (!mem_stall_o) begin
        wb_rd_data_o <= dm2reg_i ? ld_res : fwd;
        wb_rd_addr_o <= rd_addr_i;
        wb_reg_wr_o  <= wb_we;
      end
      if (state_q == ST_ACCESS && dm_ack_i) hold_q <= ld_word;
    end
  end

endmodule
